load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 53 +++++
 rtl/load_store_unit.sv | 124 ++++++++++++
 tb/tb_load_store_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 width codes, FSM states,
// lane widths and the funct3 legality check.
package lsu_pkg;

  localparam int WORD_W = 32;
  localparam int HALF_W = 16;
  localparam int BYTE_W = 8;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } lsu_state_e;

  // Unsigned widths only exist for loads.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data and merges sub-word
// store data into a read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        lane,
  input  logic [WORD_W-1:0] word,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_val,
  output logic [WORD_W-1:0] merged
);

  logic [BYTE_W-1:0] byte_v;
  logic [HALF_W-1:0] half_v;

  always_comb begin
    byte_v = word[7:0];
    case (lane)
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    half_v = lane[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_val = {{(WORD_W-BYTE_W){byte_v[BYTE_W-1]}}, byte_v};
      F3_BU:   load_val = {{(WORD_W-BYTE_W){1'b0}}, byte_v};
      F3_H:    load_val = {{(WORD_W-HALF_W){half_v[HALF_W-1]}}, half_v};
      F3_HU:   load_val = {{(WORD_W-HALF_W){1'b0}}, half_v};
      default: load_val = word;
    endcase

    merged = word;
    case (funct3[1:0])
      2'b00: begin
        case (lane)
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          2'd3:    merged[31:24] = wdata[7:0];
          default: merged[7:0]   = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between core and a word-wide memory without byte enables.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/HU/SH/W/SW instead of truncating.
//
// state   | meaning
// IDLE    | waiting for i_req
// RD_ADDR | read address presented, memory registering it
// RD_DATA | read word arrives; load completes or sub-word store merges
// WR      | write enable high for one cycle, or rejected access reporting o_err
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [WORD_W-1:0] o_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [WORD_W-1:0] o_mem_data,
  output logic              o_mem_wre,
  input  logic [WORD_W-1:0] i_mem_rdata
);

  lsu_state_e        state;
  logic [2:0]        op_f3;
  logic [1:0]        op_lane;
  logic [WORD_W-1:0] op_wdata;
  logic              op_we;
  logic              op_bad;
  logic              misalign;
  logic              accept_ok;
  logic [WORD_W-1:0] load_val;
  logic [WORD_W-1:0] merged;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                    ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign accept_ok = f3_legal(i_we, i_funct3) && !misalign;
  assign o_busy    = (state != IDLE);

  lsu_align u_align (
    .funct3   (op_f3),
    .lane     (op_lane),
    .word     (i_mem_rdata),
    .wdata    (op_wdata),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_f3      <= 3'b000;
      op_lane    <= 2'b00;
      op_wdata   <= '0;
      op_we      <= 1'b0;
      op_bad     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      o_rdata    <= '0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
      o_mem_wre  <= 1'b0;
    end else begin
      o_done <= 1'b0;
      o_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req) begin
            op_f3    <= i_funct3;
            op_lane  <= i_addr[1:0];
            op_wdata <= i_wdata;
            op_we    <= i_we;
            if (!accept_ok) begin
              // Rejected accesses reuse WR with the write enable left low.
              op_bad <= 1'b1;
              state  <= WR;
            end else begin
              op_bad     <= 1'b0;
              o_mem_addr <= {i_addr[ADDR_W-1:2], 2'b00};
              if (i_we && (i_funct3[1:0] == 2'b10)) begin
                o_mem_data <= i_wdata;
                o_mem_wre  <= 1'b1;
                state      <= WR;
              end else begin
                state <= RD_ADDR;
              end
            end
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          if (op_we) begin
            o_mem_data <= merged;
            o_mem_wre  <= 1'b1;
            state      <= WR;
          end else begin
            o_rdata <= load_val;
            o_done  <= 1'b1;
            state   <= IDLE;
          end
        end
        WR: begin
          o_mem_wre <= 1'b0;
          o_done    <= 1'b1;
          o_err     <= op_bad;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with a registered word memory model.
module tb_load_store_unit;

  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic          i_we;
  logic [2:0]    i_funct3;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_wdata;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [31:0]   o_rdata;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_data;
  logic          o_mem_wre;
  logic [31:0]   i_mem_rdata;

  logic          mem_init;
  logic [31:0]   mem [0:31];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err),
    .o_rdata     (o_rdata),
    .o_mem_addr  (o_mem_addr),
    .o_mem_data  (o_mem_data),
    .o_mem_wre   (o_mem_wre),
    .i_mem_rdata (i_mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h876543A1;
    end else if (o_mem_wre) begin
      mem[o_mem_addr[6:2]] <= o_mem_data;
    end
    i_mem_rdata <= mem[o_mem_addr[6:2]];
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [6:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
    int          wre;
    logic        chk_mem;
    int          midx;
    logic [31:0] mval;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [6:0] addr,
                              input logic [31:0] wdata, input int lat, input logic err,
                              input logic chk_rd, input logic [31:0] rdata, input int wre,
                              input logic chk_mem, input int midx, input logic [31:0] mval);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.lat = lat; v.err = err;
    v.chk_rd = chk_rd; v.rdata = rdata; v.wre = wre; v.chk_mem = chk_mem;
    v.midx = midx; v.mval = mval;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic do_op(input vec_t v, input int idx);
    int lat;
    int wres;
    logic err;
    logic [31:0] rd;
    @(negedge clk);
    i_req = 1'b1; i_we = v.we; i_funct3 = v.f3; i_addr = v.addr; i_wdata = v.wdata;
    @(posedge clk); #1;
    // scramble core inputs: the unit must work from values captured at accept
    i_req = 1'b0; i_we = ~v.we; i_funct3 = 3'b010; i_addr = 7'h7F; i_wdata = 32'h5A5A5A5A;
    chk($sformatf("v%0d_busy", idx), {31'b0, o_busy}, 32'd1);
    wres = int'(o_mem_wre);
    lat = -1; err = 1'b0; rd = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      wres += int'(o_mem_wre);
      if (o_done) begin
        lat = k; err = o_err; rd = o_rdata;
        break;
      end
    end
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_err", idx), {31'b0, err}, {31'b0, v.err});
    chk($sformatf("v%0d_wre_cycles", idx), wres, v.wre);
    if (v.chk_rd)  chk($sformatf("v%0d_rdata", idx), rd, v.rdata);
    if (v.chk_mem) chk($sformatf("v%0d_mem", idx), mem[v.midx], v.mval);
  endtask

  initial begin
    rst = 1'b1; mem_init = 1'b1;
    i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b000; i_addr = '0; i_wdata = '0;

    vecs[0]  = mk(0, 3'b000, 7'h05, 32'h0,        2, 0, 1, 32'h00000043, 0, 0, 0, 0);
    vecs[1]  = mk(0, 3'b000, 7'h04, 32'h0,        2, 0, 1, 32'hFFFFFFA1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 3'b100, 7'h04, 32'h0,        2, 0, 1, 32'h000000A1, 0, 0, 0, 0);
    vecs[3]  = mk(0, 3'b101, 7'h06, 32'h0,        2, 0, 1, 32'h00008765, 0, 0, 0, 0);
    vecs[4]  = mk(0, 3'b001, 7'h06, 32'h0,        2, 0, 1, 32'hFFFF8765, 0, 0, 0, 0);
    vecs[5]  = mk(0, 3'b001, 7'h04, 32'h0,        2, 0, 1, 32'h000043A1, 0, 0, 0, 0);
    vecs[6]  = mk(0, 3'b010, 7'h04, 32'h0,        2, 0, 1, 32'h876543A1, 0, 0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[7]  = mk(0, 3'b010, 7'h06, 32'h0,        1, 1, 0, 32'h0,        0, 0, 0, 0);
`else
    vecs[7]  = mk(0, 3'b010, 7'h06, 32'h0,        2, 0, 1, 32'h876543A1, 0, 0, 0, 0);
`endif
    vecs[8]  = mk(1, 3'b000, 7'h05, 32'h000000CC, 3, 0, 0, 32'h0, 1, 1, 1, 32'h8765CCA1);
    vecs[9]  = mk(1, 3'b010, 7'h08, 32'hDEADBEEF, 1, 0, 0, 32'h0, 1, 1, 2, 32'hDEADBEEF);
    vecs[10] = mk(0, 3'b010, 7'h08, 32'h0,        2, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0);
    vecs[11] = mk(1, 3'b001, 7'h0A, 32'h12345678, 3, 0, 0, 32'h0, 1, 1, 2, 32'h5678BEEF);
    vecs[12] = mk(0, 3'b000, 7'h0B, 32'h0,        2, 0, 1, 32'h00000056, 0, 0, 0, 0);
    vecs[13] = mk(0, 3'b011, 7'h04, 32'h0,        1, 1, 0, 32'h0, 0, 0, 0, 0);
    vecs[14] = mk(1, 3'b100, 7'h08, 32'h11111111, 1, 1, 0, 32'h0, 0, 1, 2, 32'h5678BEEF);
    vecs[15] = mk(0, 3'b110, 7'h04, 32'h0,        1, 1, 0, 32'h0, 0, 0, 0, 0);
    vecs[16] = mk(1, 3'b000, 7'h07, 32'hFFFFFF11, 3, 0, 0, 32'h0, 1, 1, 1, 32'h1165CCA1);
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[17] = mk(0, 3'b101, 7'h05, 32'h0,        1, 1, 0, 32'h0, 0, 0, 0, 0);
`else
    vecs[17] = mk(0, 3'b101, 7'h05, 32'h0,        2, 0, 1, 32'h0000CCA1, 0, 0, 0, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",     {31'b0, o_busy},    32'd0);
    chk("rst_done",     {31'b0, o_done},    32'd0);
    chk("rst_err",      {31'b0, o_err},     32'd0);
    chk("rst_rdata",    o_rdata,            32'd0);
    chk("rst_mem_addr", {25'b0, o_mem_addr}, 32'd0);
    chk("rst_mem_data", o_mem_data,         32'd0);
    chk("rst_mem_wre",  {31'b0, o_mem_wre}, 32'd0);
    @(negedge clk);
    rst = 1'b0; mem_init = 1'b0;

    // consecutive do_op calls request in the o_done cycle: back-to-back accepts
    for (int i = 0; i < NV; i++) do_op(vecs[i], i);

    // reset asserted during the write cycle of a halfword store
    @(negedge clk);
    i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b001; i_addr = 7'h04; i_wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    i_req = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rstwr_wre_before", {31'b0, o_mem_wre}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstwr_wre_async",  {31'b0, o_mem_wre}, 32'd0);
    chk("rstwr_busy_async", {31'b0, o_busy},    32'd0);
    @(posedge clk); #1;
    chk("rstwr_mem_kept", mem[1], 32'h1165CCA1);
    chk("rstwr_no_done",  {31'b0, o_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rstwr_no_done_after", {31'b0, o_done}, 32'd0);
    do_op(mk(0, 3'b010, 7'h04, 32'h0, 2, 0, 1, 32'h1165CCA1, 0, 0, 0, 0), 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
